// File: rtl/bsg_manycore_remote_req_issue.sv
// bsg_manycore_remote_req_issue: 2-entry issue FIFO with credit flow control; lock FSM under BSG_MANYCORE_ISSUE_LOCK_EN
`ifndef BSG_MANYCORE_PACKET_WIDTH
`define BSG_MANYCORE_PACKET_WIDTH(a,d,x,y) (2+((d)>>3)+(a)+(d)+2*((x)+(y)))
`endif

module bsg_manycore_remote_req_issue #(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 5,
    parameter int data_width_p = 32,
    parameter int addr_width_p = 10,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp = `BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [packet_width_lp-1:0] data_i,
    input  logic                       req_lock_i,
    input  logic                       rel_lock_i,
    input  logic                       ret_store_cntr_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [packet_width_lp-1:0] data_o,
    input  logic                       ready_i,
    input  logic                       returned_credit_i,
    input  logic                       lock_grant_v_i,
    input  logic                       lock_grant_i,
    output logic [credit_width_lp-1:0] out_credits_o,
    output logic                       store_cntr_v_o,
    output logic [credit_width_lp-1:0] store_cntr_o,
    output logic                       lock_held_o,
    output logic                       lock_wait_o
);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    logic [packet_width_lp-1:0] mem_q [2];
    logic                       rd_ptr_q, wr_ptr_q;
    logic [1:0]                 cnt_q;
    logic [credit_width_lp-1:0] credit_q, credit_d;
    logic                       store_v_q;
    logic [credit_width_lp-1:0] store_q;
    logic                       accept, pop, full;

    assign full    = cnt_q == 2'd2;
    assign accept  = v_i & ready_o;
    assign pop     = v_o & ready_i;
    assign v_o     = cnt_q != 2'd0;
    assign data_o  = mem_q[rd_ptr_q];
    assign ready_o = reset_n_i & ~full & (credit_q != '0) & ~lock_wait_o;

    always_ff @(posedge clk_i) if (accept) mem_q[wr_ptr_q] <= data_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(accept) - 2'(pop);
        end
    end

    always_comb begin
        credit_d = (accept & ~returned_credit_i) ? credit_q - 1'b1
                 : (returned_credit_i & ~accept & (credit_q != max_credits_lp)) ? credit_q + 1'b1
                 : credit_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credit_q  <= max_credits_lp;
            store_v_q <= 1'b0;
            store_q   <= '0;
        end else begin
            credit_q  <= credit_d;
            store_v_q <= ret_store_cntr_i;
            if (ret_store_cntr_i) store_q <= max_credits_lp - credit_q;
        end
    end

    assign out_credits_o  = credit_q;
    assign store_cntr_v_o = store_v_q;
    assign store_cntr_o   = store_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i)
        if (reset_n_i && returned_credit_i && !accept && credit_q == max_credits_lp)
            $error("credit returned while already at max_out_credits_p");
`endif

`ifdef BSG_MANYCORE_ISSUE_LOCK_EN
    typedef enum logic [1:0] {IDLE, WAIT, HELD} lock_state_e;
    lock_state_e state_q, state_d;

    always_ff @(posedge clk_i) state_q <= !reset_n_i ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = (accept & req_lock_i) ? WAIT : IDLE;
            WAIT: state_d = lock_grant_v_i ? (lock_grant_i ? HELD : IDLE) : WAIT;
            HELD: state_d = (accept & req_lock_i) ? WAIT : rel_lock_i ? IDLE : HELD;
            default: state_d = IDLE;
        endcase
    end

    assign lock_held_o = state_q == HELD;
    assign lock_wait_o = state_q == WAIT;
`else
    logic lock_unused;
    assign lock_unused = &{req_lock_i, rel_lock_i, lock_grant_v_i, lock_grant_i};
    assign lock_held_o = 1'b0;
    assign lock_wait_o = 1'b0;
`endif
endmodule

// File: tb/tb_bsg_manycore_remote_req_issue.sv
// tb_bsg_manycore_remote_req_issue: directed bench for the issue stage; lock cases follow BSG_MANYCORE_ISSUE_LOCK_EN
module tb_bsg_manycore_remote_req_issue;
    localparam int PW = 66;

    logic clk = 1'b0;
    logic reset_n;
    logic v, req_lock, rel_lock, ret_sc, rdy_in, ret_cr, gnt_v, gnt;
    logic [PW-1:0] din, dout;
    logic rdy_out, vout, sc_v, held, waiting;
    logic [4:0] credits, sc;

    logic v2, rdy_in2, ret_cr2;
    logic [PW-1:0] din2, dout2;
    logic rdy_out2, vout2, sc_v2, held2, waiting2;
    logic [1:0] credits2, sc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_manycore_remote_req_issue #(.x_cord_width_p(4), .y_cord_width_p(5), .data_width_p(32),
        .addr_width_p(10), .max_out_credits_p(16)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .data_i(din), .req_lock_i(req_lock),
        .rel_lock_i(rel_lock), .ret_store_cntr_i(ret_sc), .ready_o(rdy_out), .v_o(vout),
        .data_o(dout), .ready_i(rdy_in), .returned_credit_i(ret_cr), .lock_grant_v_i(gnt_v),
        .lock_grant_i(gnt), .out_credits_o(credits), .store_cntr_v_o(sc_v), .store_cntr_o(sc),
        .lock_held_o(held), .lock_wait_o(waiting));

    bsg_manycore_remote_req_issue #(.x_cord_width_p(4), .y_cord_width_p(5), .data_width_p(32),
        .addr_width_p(10), .max_out_credits_p(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v2), .data_i(din2), .req_lock_i(1'b0),
        .rel_lock_i(1'b0), .ret_store_cntr_i(1'b0), .ready_o(rdy_out2), .v_o(vout2),
        .data_o(dout2), .ready_i(rdy_in2), .returned_credit_i(ret_cr2), .lock_grant_v_i(1'b0),
        .lock_grant_i(1'b0), .out_credits_o(credits2), .store_cntr_v_o(sc_v2), .store_cntr_o(sc2),
        .lock_held_o(held2), .lock_wait_o(waiting2));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pkt(input int i);
        return PW'(i * 32'h1111 + 32'h5A5) | {2'b10, {(PW-2){1'b0}}};
    endfunction

    initial begin
        reset_n = 0; v = 0; req_lock = 0; rel_lock = 0; ret_sc = 0; rdy_in = 0;
        ret_cr = 0; gnt_v = 0; gnt = 0; din = '0;
        v2 = 0; rdy_in2 = 0; ret_cr2 = 0; din2 = '0;
        step(); step();
        check("rst_ready", rdy_out, 0);
        check("rst_v", vout, 0);
        check("rst_credits", credits, 16);
        check("rst_sc_v", sc_v, 0);
        check("rst_sc", sc, 0);
        check("rst_held", held, 0);
        check("rst_wait", waiting, 0);
        reset_n = 1;
        step();
        check("idle_ready", rdy_out, 1);
        check("idle_credits", credits, 16);
        check("idle_v", vout, 0);

        rdy_in = 1;
        for (int i = 0; i < 4; i++) begin
            v = 1; din = pkt(i);
            #1 check($sformatf("b2b_ready%0d", i), rdy_out, 1);
            step();
            check($sformatf("b2b_v%0d", i), vout, 1);
            check($sformatf("b2b_data%0d", i), dout, pkt(i));
        end
        v = 0;
        step();
        check("b2b_drained", vout, 0);
        check("b2b_credits", credits, 12);

        ret_cr = 1;
        step();
        ret_cr = 0;
        check("ret_credits", credits, 13);
        ret_sc = 1;
        step();
        ret_sc = 0;
        check("query_v", sc_v, 1);
        check("query_cnt", sc, 3);
        step();
        check("query_v_drop", sc_v, 0);

        rdy_in = 0;
        v = 1; din = pkt(10);
        step();
        din = pkt(11);
        step();
        din = pkt(12);
        check("bp_full_ready", rdy_out, 0);
        check("bp_head", dout, pkt(10));
        step();
        check("bp_stable", dout, pkt(10));
        check("bp_credits", credits, 11);
        rdy_in = 1;
        step();
        check("bp_pop_head", dout, pkt(11));
        check("bp_ready_back", rdy_out, 1);
        step();
        check("bp_pushpop_v", vout, 1);
        check("bp_pushpop_data", dout, pkt(12));
        v = 0;
        step();
        check("bp_empty", vout, 0);
        check("bp_credits_end", credits, 10);

`ifdef BSG_MANYCORE_ISSUE_LOCK_EN
        v = 1; req_lock = 1; din = pkt(20);
        step();
        v = 0; req_lock = 0;
        check("lk_wait", waiting, 1);
        check("lk_ready", rdy_out, 0);
        check("lk_not_held", held, 0);
        gnt_v = 1; gnt = 1;
        step();
        gnt_v = 0; gnt = 0;
        check("lk_held", held, 1);
        check("lk_wait_clr", waiting, 0);
        rel_lock = 1;
        step();
        rel_lock = 0;
        check("lk_released", held, 0);
        v = 1; req_lock = 1; din = pkt(21);
        step();
        v = 0; req_lock = 0;
        check("lk_wait2", waiting, 1);
        gnt_v = 1; gnt = 0;
        step();
        gnt_v = 0;
        check("lk_denied_held", held, 0);
        check("lk_denied_wait", waiting, 0);
        check("lk_credits", credits, 8);
`else
        v = 1; req_lock = 1; din = pkt(20);
        step();
        v = 0; req_lock = 0;
        check("nolk_wait", waiting, 0);
        check("nolk_ready", rdy_out, 1);
        check("nolk_data", dout, pkt(20));
        gnt_v = 1; gnt = 1;
        step();
        gnt_v = 0; gnt = 0;
        check("nolk_held", held, 0);
        check("nolk_credits", credits, 9);
`endif

        rdy_in2 = 1; v2 = 1; din2 = pkt(30);
        step();
        check("ex_cred1", credits2, 1);
        din2 = pkt(31);
        step();
        check("ex_cred0", credits2, 0);
        check("ex_third_blocked", rdy_out2, 0);
        din2 = pkt(32);
        step();
        check("ex_hold0", credits2, 0);
        ret_cr2 = 1;
        step();
        ret_cr2 = 0;
        check("ex_ret_cred", credits2, 1);
        check("ex_ret_ready", rdy_out2, 1);
        ret_cr2 = 1;
        step();
        ret_cr2 = 0; v2 = 0;
        check("ex_simul_cred", credits2, 1);
        check("ex_simul_data", dout2, pkt(32));

        rdy_in = 0; v = 1; din = pkt(40);
        step();
        v = 0;
        check("mid_v", vout, 1);
        reset_n = 0;
        step();
        check("mid_rst_v", vout, 0);
        check("mid_rst_ready", rdy_out, 0);
        check("mid_rst_credits", credits, 16);
        check("mid_rst_wait", waiting, 0);
        reset_n = 1;
        step();
        check("mid_after_ready", rdy_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
